// File: rtl/cpu_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Define CPU_BCD_SIGNED_EN to accept two's-complement input and report its sign.
module cpu_bcd_seq #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  sign
);

  localparam int DW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_reg, state_next;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [DW-1:0]        digit_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 ovf_reg;
  logic [BIN_WIDTH-1:0] load_mag;
  logic [DW-1:0]        adj;
  logic [DW+BIN_WIDTH:0] chain;
  logic                 last_step;

  // Correct every digit before the shift so a digit >= 5 carries cleanly into the next.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (digit_reg[4*gi +: 4] >= 4'd5) ?
                              digit_reg[4*gi +: 4] + 4'd3 : digit_reg[4*gi +: 4];
    end
  endgenerate

  // Top bit of chain is the bit leaving the most significant digit.
  assign chain     = {adj, shift_reg, 1'b0};
  assign last_step = (cnt_reg == CNT_W'(1));

`ifdef CPU_BCD_SIGNED_EN
  logic sign_acc;

  assign load_mag = binary[BIN_WIDTH-1] ? (~binary + 1'b1) : binary;

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_acc <= 1'b0;
      sign     <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      sign_acc <= binary[BIN_WIDTH-1];
    end else if (state_reg == SHIFT && last_step) begin
      sign <= sign_acc;
    end
  end
`else
  assign load_mag = binary;
  assign sign     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = SHIFT;
      end
      SHIFT: if (last_step) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      digit_reg <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          shift_reg <= load_mag;
          digit_reg <= '0;
          cnt_reg   <= CNT_W'(BIN_WIDTH);
          ovf_reg   <= 1'b0;
        end
        SHIFT: begin
          shift_reg <= chain[BIN_WIDTH-1:0];
          digit_reg <= chain[DW+BIN_WIDTH-1:BIN_WIDTH];
          cnt_reg   <= cnt_reg - 1'b1;
          ovf_reg   <= ovf_reg | chain[DW+BIN_WIDTH];
          if (last_step) begin
            bcd      <= chain[DW+BIN_WIDTH-1:BIN_WIDTH];
            overflow <= ovf_reg | chain[DW+BIN_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bcd_seq.sv
// Scoreboard bench for cpu_bcd_seq: two instances (3 and 2 digits) driven in lockstep,
// expected results computed arithmetically from the input value.
module tb_cpu_bcd_seq;

  localparam int BW = 8;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
    logic        sgn;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  binary;
  logic        busy_a, done_a, ovf_a, sign_a;
  logic        busy_b, done_b, ovf_b, sign_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   idle_chk = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .reset(reset), .start(start), .binary(binary),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .sign(sign_a));

  cpu_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .binary(binary),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .sign(sign_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] v, input int acc);
    exp_t e;
    int   mag;
    int   p;
`ifdef CPU_BCD_SIGNED_EN
    e.sgn = v[7];
    mag   = v[7] ? 256 - int'(v) : int'(v);
`else
    e.sgn = 1'b0;
    mag   = int'(v);
`endif
    p = 1;
    for (int i = 0; i < 3; i++) begin
      e.bcd3[4*i +: 4] = 4'((mag / p) % 10);
      if (i < 2) e.bcd2[4*i +: 4] = 4'((mag / p) % 10);
      p = p * 10;
    end
    e.ovf3 = (mag >= 1000);
    e.ovf2 = (mag >= 100);
    e.bin  = v;
    e.acc  = acc;
    return e;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy_a) chk("idle_timeout", 32'(busy_a), 32'd0);
  endtask

  // Issue one conversion, then scribble on start/binary for its whole duration.
  task automatic issue(input logic [7:0] v);
    int t = 0;
    wait_idle();
    start  = 1'b1;
    binary = v;
    q.push_back(model(v, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    while (busy_a && t < 100) begin
      start  = 1'($urandom_range(0, 1));
      binary = 8'($urandom);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (idle_chk) begin
        chk("busy_after_done", 32'(busy_a), 32'd0);
        idle_chk = 0;
      end
      if (!reset && (done_a || done_b)) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done_a), 32'd0);
        end else begin
          e = q.pop_front();
          $display("txn bin=%02h bcd3=%03h ovf3=%0b bcd2=%02h ovf2=%0b sign=%0b cyc=%0d",
                   e.bin, bcd_a, ovf_a, bcd_b, ovf_b, sign_a, cyc);
          chk("latency",   32'(cyc),    32'(e.acc + BW));
          chk("done_a",    32'(done_a), 32'd1);
          chk("done_b",    32'(done_b), 32'd1);
          chk("busy_done", 32'(busy_a), 32'd1);
          chk("bcd3",      32'(bcd_a),  32'(e.bcd3));
          chk("ovf3",      32'(ovf_a),  32'(e.ovf3));
          chk("bcd2",      32'(bcd_b),  32'(e.bcd2));
          chk("ovf2",      32'(ovf_b),  32'(e.ovf2));
          chk("sign",      32'(sign_a), 32'(e.sgn));
          chk("sign_b",    32'(sign_b), 32'(e.sgn));
          idle_chk = 1;
        end
      end
    end
  end

  initial begin
    logic [7:0] fixed [12] = '{8'd255, 8'd0, 8'd9, 8'd100, 8'd99, 8'd200,
                               8'h80, 8'hFF, 8'h7F, 8'd1, 8'd254, 8'd128};
    int t;
    reset  = 1'b1;
    start  = 1'b0;
    binary = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a),  32'd0);
    chk("rst_done", 32'(done_a),  32'd0);
    chk("rst_bcd",  32'(bcd_a),   32'd0);
    chk("rst_ovf",  32'(ovf_a),   32'd0);
    chk("rst_sign", 32'(sign_a),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (fixed[i]) issue(fixed[i]);
    for (int i = 0; i < 40; i++) issue(8'($urandom_range(0, 255)));

    // Abort a conversion of 42 in its 4th SHIFT cycle; no result may appear.
    issue(8'd200);
    wait_idle();
    start  = 1'b1;
    binary = 8'd42;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_bcd",  32'(bcd_a),  32'd0);
    chk("abort_ovf",  32'(ovf_a),  32'd0);
    chk("abort_bcdb", 32'(bcd_b),  32'd0);
    reset = 1'b0;
    repeat (14) @(negedge clk);

    issue(8'd42);
    issue(8'd73);

    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_bcd_seq.md
Name: cpu_bcd_seq

Overview:
Iterative binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It is a parametrised, registered successor to the CPU's combinational 8-bit BCD unit. It serves the FX33 store-BCD path and the debug/score display path, trading latency for area at wide input widths. A start/busy/done handshake lets the CPU sequencer stall until the result is ready.

Parameters:
BIN_WIDTH, 8, width of the binary input in bits (>=2).
DIGITS, 3, number of BCD output digits; the result is 4*DIGITS bits wide.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  conversion request; sampled only in IDLE.
binary  in  BIN_WIDTH  value to convert; sampled on the same edge as an accepted start.
busy  out  1  high while a conversion is in progress (state != IDLE).
done  out  1  one-cycle pulse; result is valid from this cycle onward.
bcd  out  4*DIGITS  packed digits, most significant digit in the top nibble, held until the next done.
overflow  out  1  the value did not fit in DIGITS digits; held with bcd.
sign  out  1  sign of the input (see Optional Feature).

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, bcd=0, overflow=0, sign=0, and all internal registers cleared. Reset mid-conversion aborts the conversion with no done pulse.
- States:
  - IDLE: start=1 moves to SHIFT on the next edge, latches binary into the shift register, clears the digit accumulator, sets the bit counter to BIN_WIDTH and clears the overflow accumulator.
  - SHIFT: each edge performs one step, as follows.
    - Add 3 to every digit that is >=5.
    - Shift the {digits, shift register} chain left by 1; the input MSB enters digit 0 bit 0.
    - OR the bit leaving the top digit's bit 3 into the overflow accumulator.
    - Decrement the counter.
    - On the edge performing the BIN_WIDTH-th shift: write the digits to bcd, overflow to overflow, sign to sign, and go to DONE.
  - DONE: done=1 for exactly this cycle, busy=1; the next edge goes to IDLE unconditionally.
- Timing: start accepted at edge N. The result registers update at edge N+BIN_WIDTH. done is high in the cycle following that edge. busy is high from after edge N until after edge N+BIN_WIDTH+1. Throughput is one conversion per BIN_WIDTH+2 cycles.
- start while busy=1, including the DONE cycle, is ignored; binary changes during a conversion have no effect.
- Digit arithmetic: the add-3 correction is applied before the shift, matching the existing combinational unit exactly for all 8-bit inputs. Digit carries are 4 bits wide; nothing wraps silently, because bits leaving the top digit set overflow.
- When overflow=1, bcd holds the low DIGITS digits of the true decimal value (the value modulo 10^DIGITS).
- bcd, overflow and sign change only at the DONE-entry edge or on reset.

Optional Feature:
CPU_BCD_SIGNED_EN.
- Defined: binary is treated as two's complement.
  - At load, if the MSB is 1, the shift register receives the two's-complement negation (magnitude) and a sign flag is captured; sign is output with the result.
  - -2^(BIN_WIDTH-1) converts correctly because its magnitude fits in BIN_WIDTH unsigned bits.
  - Latency is unchanged; the negation is done in the load cycle.
- Undefined: binary is unsigned, the negate logic is absent, and sign is tied to 0.

Test Plan:
1. Default parameters, reset, then start with binary=255 at edge N -> done pulses exactly one cycle after edge N+8, bcd=12'h255, overflow=0, busy deasserted after edge N+9.
2. Default parameters, binary=0, then binary=9, then binary=100 back-to-back as soon as busy=0 -> bcd=12'h000, 12'h009, 12'h100 in sequence, with each done spaced 10 cycles apart.
3. BIN_WIDTH=16, DIGITS=5, binary=65535 -> bcd=20'h65535 with done one cycle after edge N+16; then binary=12345 -> 20'h12345.
4. BIN_WIDTH=8, DIGITS=2, binary=100 -> overflow=1, bcd=8'h00; then binary=99 -> overflow=0, bcd=8'h99.
5. Default parameters, start with binary=200, pulse start with binary=7 during SHIFT and again during DONE, then assert reset at the 4th SHIFT cycle of a following conversion of 42 -> first result 12'h200 (ignored starts cause no effect); after reset, bcd=0, done never pulses for 42, state=IDLE.
6. CPU_BCD_SIGNED_EN defined, default parameters: binary=8'h80 -> sign=1, bcd=12'h128; binary=8'hFF -> sign=1, bcd=12'h001; binary=8'h7F -> sign=0, bcd=12'h127.
